// File: rtl/ballot_input_conditioner_pkg.sv
// Shared definitions for the ballot front end: FSM states and candidate indices.
// The candidate indices are shared with the downstream vote counter.
package ballot_input_conditioner_pkg;

    typedef enum logic [2:0] {
        WAIT_VOTER = 3'd0,
        ARMED      = 3'd1,
        COLLECT    = 3'd2,
        EMIT       = 3'd3,
        HOLDOFF    = 3'd4
    } state_e;

    localparam int unsigned CAND_A   = 0;
    localparam int unsigned CAND_B   = 1;
    localparam int unsigned CAND_C   = 2;
    localparam int unsigned NUM_CAND = 3;

    // A ballot is valid only when exactly one candidate was selected
    function automatic logic is_single_choice(input logic [NUM_CAND-1:0] i_sel);
        return (i_sel == 3'b001) || (i_sel == 3'b010) || (i_sel == 3'b100);
    endfunction

endpackage

// File: rtl/ballot_input_conditioner_btn_debounce.sv
// One candidate button: 2-FF synchroniser, stable-count debouncer and rising-edge pulse.
module ballot_input_conditioner_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Input has disagreed for DEBOUNCE_CYCLES samples in a row
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (r_cnt < CNT_W'(DEBOUNCE_CYCLES));
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/ballot_input_conditioner.sv
// Voter-session front end: debounces three candidate buttons, collects one session's
// presses over a short window and emits a single vote or reject pulse.
module ballot_input_conditioner
    import ballot_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES   = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_session_start,
    input  logic i_btn_A_raw,
    input  logic i_btn_B_raw,
    input  logic i_btn_C_raw,
    output logic o_vote_A,
    output logic o_vote_B,
    output logic o_vote_C,
    output logic o_vote_reject,
    output logic o_voter_ready,
    output logic o_busy
);

    logic [NUM_CAND-1:0] w_raw;
    logic [NUM_CAND-1:0] w_level;
    logic [NUM_CAND-1:0] w_rise;

    assign w_raw[CAND_A] = i_btn_A_raw;
    assign w_raw[CAND_B] = i_btn_B_raw;
    assign w_raw[CAND_C] = i_btn_C_raw;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        ballot_input_conditioner_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_btn_raw(w_raw[g]),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g])
        );
    end

    state_e              r_state;
    state_e              w_state_d;
    logic [NUM_CAND-1:0] r_sel;
    logic [NUM_CAND-1:0] w_sel_d;
    logic [CNT_W-1:0]    r_win;
    logic [CNT_W-1:0]    w_win_d;
    logic [NUM_CAND-1:0] r_vote;
    logic [NUM_CAND-1:0] w_vote_d;
    logic                r_reject;
    logic                w_reject_d;
    logic                r_ready;
    logic                r_busy;

    always_comb begin
        w_state_d  = r_state;
        w_sel_d    = r_sel;
        w_win_d    = r_win;
        w_vote_d   = '0;
        w_reject_d = 1'b0;

        unique case (r_state)
            WAIT_VOTER: begin
                w_sel_d = '0;
                if (i_session_start) w_state_d = ARMED;
            end
            ARMED: begin
                if (|w_rise) begin
                    w_sel_d   = w_rise;
                    w_win_d   = '0;
                    w_state_d = COLLECT;
                end
            end
            COLLECT: begin
                w_sel_d = r_sel | w_rise;
                if (r_win >= CNT_W'(WINDOW_CYCLES - 1)) w_state_d = EMIT;
                else                                   w_win_d   = r_win + 1'b1;
            end
            EMIT: begin
                // Fires regardless of enable so a completed ballot is never lost
                if (is_single_choice(r_sel)) w_vote_d   = r_sel;
                else                         w_reject_d = 1'b1;
                w_state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (w_level == '0) w_state_d = WAIT_VOTER;
            end
            default: w_state_d = WAIT_VOTER;
        endcase

        if (!i_enable) begin
            w_state_d = WAIT_VOTER;
            w_sel_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= WAIT_VOTER;
            r_sel    <= '0;
            r_win    <= '0;
            r_vote   <= '0;
            r_reject <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_sel    <= w_sel_d;
            r_win    <= w_win_d;
            r_vote   <= w_vote_d;
            r_reject <= w_reject_d;
            r_ready  <= (w_state_d == ARMED);
            r_busy   <= (w_state_d == COLLECT) || (w_state_d == EMIT) || (w_state_d == HOLDOFF);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (r_win < CNT_W'(WINDOW_CYCLES));
        end
    end

    assign o_vote_A      = r_vote[CAND_A];
    assign o_vote_B      = r_vote[CAND_B];
    assign o_vote_C      = r_vote[CAND_C];
    assign o_vote_reject = r_reject;
    assign o_voter_ready = r_ready;
    assign o_busy        = r_busy;

endmodule
